// File: rtl/cmd_frame_decoder_if.sv
// Byte-in / command-out bundle between the data synchronizer, the frame decoder
// and the system controller.
interface cmd_frame_decoder_if #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [BUS_WIDTH-1:0]  Rx_Data;
  logic                  Rx_Valid;
  logic                  Cmd_Valid;
  logic [1:0]            Cmd_Type;
  logic [ADDR_WIDTH-1:0] Cmd_Addr;
  logic [BUS_WIDTH-1:0]  Cmd_Data;
  logic [BUS_WIDTH-1:0]  Cmd_OpA;
  logic [BUS_WIDTH-1:0]  Cmd_OpB;
  logic [3:0]            Cmd_Func;
  logic                  Frame_Error;
  logic                  Busy;

  modport master (
    output Rx_Data, Rx_Valid,
    input  Cmd_Valid, Cmd_Type, Cmd_Addr, Cmd_Data, Cmd_OpA, Cmd_OpB,
           Cmd_Func, Frame_Error, Busy
  );

  modport slave (
    input  Rx_Data, Rx_Valid,
    output Cmd_Valid, Cmd_Type, Cmd_Addr, Cmd_Data, Cmd_OpA, Cmd_OpB,
           Cmd_Func, Frame_Error, Busy
  );
endinterface

// File: rtl/cmd_frame_decoder.sv
// Assembles synchronized receive bytes into command frames and emits one
// registered strobe per decoded command; aborts stalled frames on timeout.
module cmd_frame_decoder #(
  parameter int BUS_WIDTH      = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 CLK,
  input logic                 RST,
  cmd_frame_decoder_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [BUS_WIDTH-1:0] OP_WR  = BUS_WIDTH'(8'hAA);
  localparam logic [BUS_WIDTH-1:0] OP_RD  = BUS_WIDTH'(8'hBB);
  localparam logic [BUS_WIDTH-1:0] OP_ALU = BUS_WIDTH'(8'hCC);
  localparam logic [BUS_WIDTH-1:0] OP_NOP = BUS_WIDTH'(8'hDD);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_ALU_A   = 3'd4;
  localparam logic [2:0] S_ALU_B   = 3'd5;
  localparam logic [2:0] S_ALU_FN  = 3'd6;
  localparam logic [2:0] S_NOP_FN  = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [BUS_WIDTH-1:0]  opa_hold_q, opa_hold_d;
  logic [BUS_WIDTH-1:0]  opb_hold_q, opb_hold_d;

  logic                  cmd_valid_q, cmd_valid_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [1:0]            type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic [BUS_WIDTH-1:0]  opa_q, opa_d;
  logic [BUS_WIDTH-1:0]  opb_q, opb_d;
  logic [3:0]            func_q, func_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_hold_d = addr_hold_q;
    opa_hold_d  = opa_hold_q;
    opb_hold_d  = opb_hold_q;
    cmd_valid_d = 1'b0;
    err_d       = 1'b0;
    type_d      = type_q;
    addr_d      = addr_q;
    data_d      = data_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    func_d      = func_q;

    if (bus.Rx_Valid) begin
      // An accepted byte always restarts the inter-byte window, even on expiry.
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (bus.Rx_Data == OP_WR)       state_d = S_WR_ADDR;
          else if (bus.Rx_Data == OP_RD)  state_d = S_RD_ADDR;
          else if (bus.Rx_Data == OP_ALU) state_d = S_ALU_A;
          else if (bus.Rx_Data == OP_NOP) state_d = S_NOP_FN;
          else                            err_d   = 1'b1;
        end
        S_WR_ADDR: begin
          addr_hold_d = bus.Rx_Data[ADDR_WIDTH-1:0];
          state_d     = S_WR_DATA;
        end
        S_WR_DATA: begin
          cmd_valid_d = 1'b1;
          type_d      = 2'b00;
          addr_d      = addr_hold_q;
          data_d      = bus.Rx_Data;
          state_d     = S_IDLE;
        end
        S_RD_ADDR: begin
          cmd_valid_d = 1'b1;
          type_d      = 2'b01;
          addr_d      = bus.Rx_Data[ADDR_WIDTH-1:0];
          state_d     = S_IDLE;
        end
        S_ALU_A: begin
          opa_hold_d = bus.Rx_Data;
          state_d    = S_ALU_B;
        end
        S_ALU_B: begin
          opb_hold_d = bus.Rx_Data;
          state_d    = S_ALU_FN;
        end
        S_ALU_FN: begin
          cmd_valid_d = 1'b1;
          type_d      = 2'b10;
          opa_d       = opa_hold_q;
          opb_d       = opb_hold_q;
          func_d      = bus.Rx_Data[3:0];
          state_d     = S_IDLE;
        end
        default: begin
          cmd_valid_d = 1'b1;
          type_d      = 2'b11;
          func_d      = bus.Rx_Data[3:0];
          state_d     = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_inc == TO_LAST) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end else begin
      cnt_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_hold_q <= '0;
      opa_hold_q  <= '0;
      opb_hold_q  <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      type_q      <= 2'b00;
      addr_q      <= '0;
      data_q      <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      func_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_hold_q <= addr_hold_d;
      opa_hold_q  <= opa_hold_d;
      opb_hold_q  <= opb_hold_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      func_q      <= func_d;
    end
  end

  assign bus.Cmd_Valid   = cmd_valid_q;
  assign bus.Frame_Error = err_q;
  assign bus.Busy        = busy_q;
  assign bus.Cmd_Type    = type_q;
  assign bus.Cmd_Addr    = addr_q;
  assign bus.Cmd_Data    = data_q;
  assign bus.Cmd_OpA     = opa_q;
  assign bus.Cmd_OpB     = opb_q;
  assign bus.Cmd_Func    = func_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder with a 16-cycle inter-byte timeout.
module tb_cmd_frame_decoder;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cv_pulses = 0;
  int   fe_pulses = 0;
  int   both_high = 0;
  int   first_fe;

  always #5 CLK = ~CLK;

  cmd_frame_decoder_if #(.BUS_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  cmd_frame_decoder #(
    .BUS_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // Strobes are counted at the falling edge, once per high cycle.
  always @(negedge CLK) begin
    if (bus.Cmd_Valid)   cv_pulses++;
    if (bus.Frame_Error) fe_pulses++;
    if (bus.Cmd_Valid && bus.Frame_Error) both_high++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    bus.Rx_Valid = 1'b1;
    bus.Rx_Data  = b;
  endtask

  task automatic idle();
    @(negedge CLK);
    bus.Rx_Valid = 1'b0;
    bus.Rx_Data  = 8'h00;
  endtask

  initial begin
    bus.Rx_Valid = 1'b0;
    bus.Rx_Data  = 8'h00;
    RST = 1'b0;
    idle(); idle();
    check_eq("rst_cv",   32'(bus.Cmd_Valid), 0);
    check_eq("rst_fe",   32'(bus.Frame_Error), 0);
    check_eq("rst_busy", 32'(bus.Busy), 0);
    check_eq("rst_fields", {bus.Cmd_Type, bus.Cmd_Addr, bus.Cmd_Data, bus.Cmd_OpA[3:0], bus.Cmd_Func}, 0);
    check_eq("rst_opb",  32'(bus.Cmd_OpB), 0);
    RST = 1'b1;

    // Partial frame interrupted by reset
    send(8'hAA); send(8'h05);
    check_eq("mid_busy", 32'(bus.Busy), 1);
    idle();
    RST = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(bus.Busy), 0);
    check_eq("midrst_cv", 32'(bus.Cmd_Valid), 0);
    idle();
    RST = 1'b1;
    idle();

    send(8'hAA); send(8'h05); send(8'h3C); idle();
    check_eq("wr_cv",   32'(bus.Cmd_Valid), 1);
    check_eq("wr_type", 32'(bus.Cmd_Type), 0);
    check_eq("wr_addr", 32'(bus.Cmd_Addr), 5);
    check_eq("wr_data", 32'(bus.Cmd_Data), 32'h3C);
    check_eq("wr_busy", 32'(bus.Busy), 0);
    idle();
    check_eq("wr_cv_1cyc", 32'(bus.Cmd_Valid), 0);
    check_eq("wr_hold", 32'(bus.Cmd_Data), 32'h3C);

    // Read then ALU, back to back
    send(8'hBB); send(8'h0A); send(8'hCC);
    check_eq("rd_cv",   32'(bus.Cmd_Valid), 1);
    check_eq("rd_type", 32'(bus.Cmd_Type), 1);
    check_eq("rd_addr", 32'(bus.Cmd_Addr), 32'hA);
    send(8'h12);
    check_eq("b2b_busy", 32'(bus.Busy), 1);
    send(8'h34); send(8'h03); idle();
    check_eq("alu_cv",   32'(bus.Cmd_Valid), 1);
    check_eq("alu_type", 32'(bus.Cmd_Type), 2);
    check_eq("alu_opa",  32'(bus.Cmd_OpA), 32'h12);
    check_eq("alu_opb",  32'(bus.Cmd_OpB), 32'h34);
    check_eq("alu_func", 32'(bus.Cmd_Func), 3);
    check_eq("alu_data_kept", 32'(bus.Cmd_Data), 32'h3C);
    check_eq("alu_addr_kept", 32'(bus.Cmd_Addr), 32'hA);

    // No-operand ALU then a bad opcode
    send(8'hDD); send(8'h0F); send(8'h57);
    check_eq("nop_cv",   32'(bus.Cmd_Valid), 1);
    check_eq("nop_type", 32'(bus.Cmd_Type), 3);
    check_eq("nop_func", 32'(bus.Cmd_Func), 32'hF);
    idle();
    check_eq("bad_fe",   32'(bus.Frame_Error), 1);
    check_eq("bad_cv",   32'(bus.Cmd_Valid), 0);
    check_eq("bad_busy", 32'(bus.Busy), 0);
    idle();
    check_eq("bad_fe_1cyc", 32'(bus.Frame_Error), 0);

    // Timeout: error 16 cycles after the last byte
    send(8'hCC); send(8'h11);
    first_fe = 0;
    for (int k = 1; k <= 16; k++) begin
      idle();
      if (bus.Frame_Error && first_fe == 0) first_fe = k;
      if (k == 15) check_eq("to_busy_before", 32'(bus.Busy), 1);
    end
    check_eq("to_cycle", 32'(first_fe), 16);
    check_eq("to_busy",  32'(bus.Busy), 0);
    check_eq("to_cv",    32'(bus.Cmd_Valid), 0);
    send(8'hAA); send(8'h01); send(8'h02); idle();
    check_eq("post_to_cv",   32'(bus.Cmd_Valid), 1);
    check_eq("post_to_addr", 32'(bus.Cmd_Addr), 1);
    check_eq("post_to_data", 32'(bus.Cmd_Data), 2);

    // Opcode values inside a frame are payload
    send(8'hAA); send(8'hAA); send(8'hBB); idle();
    check_eq("pay_cv",   32'(bus.Cmd_Valid), 1);
    check_eq("pay_type", 32'(bus.Cmd_Type), 0);
    check_eq("pay_addr", 32'(bus.Cmd_Addr), 32'hA);
    check_eq("pay_data", 32'(bus.Cmd_Data), 32'hBB);
    check_eq("pay_fe",   32'(bus.Frame_Error), 0);

    // Byte arriving in the expiry cycle wins
    send(8'hAA);
    for (int k = 1; k <= 14; k++) idle();
    send(8'h01);
    check_eq("exp_busy", 32'(bus.Busy), 1);
    send(8'h02);
    check_eq("exp_fe", 32'(bus.Frame_Error), 0);
    idle();
    check_eq("exp_cv",   32'(bus.Cmd_Valid), 1);
    check_eq("exp_addr", 32'(bus.Cmd_Addr), 1);
    check_eq("exp_data", 32'(bus.Cmd_Data), 2);
    idle(); idle();

    check_eq("total_cv", 32'(cv_pulses), 7);
    check_eq("total_fe", 32'(fe_pulses), 2);
    check_eq("exclusive", 32'(both_high), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_decoder.md
# cmd_frame_decoder

Byte-level command frame decoder sitting directly downstream of the data synchronizer in the system clock domain. Consumes the synchronized receive byte and its single-cycle enable pulse, assembles multi-byte command frames (register write, register read, ALU with operands, ALU without operands), and presents each decoded command to the system controller as one registered single-cycle strobe with stable fields. Also aborts stalled frames on an inter-byte timeout and flags unknown opcodes.

## Interface
- BUS_WIDTH, 8, byte width; must match the synchronizer bus width
- ADDR_WIDTH, 4, register-file address width; taken from the LSBs of the address byte
- TIMEOUT_CYCLES, 1024, max CLK cycles allowed between bytes of one frame (≥2)
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- Rx_Data  in  BUS_WIDTH  synchronized byte; sampled only when Rx_Valid=1
- Rx_Valid  in  1  one-cycle byte strobe; back-to-back cycles legal
- Cmd_Valid  out  1  one-cycle strobe: complete frame decoded
- Cmd_Type  out  2  00 write, 01 read, 10 ALU with operands, 11 ALU no operands
- Cmd_Addr  out  ADDR_WIDTH  register address (write/read)
- Cmd_Data  out  BUS_WIDTH  write data
- Cmd_OpA  out  BUS_WIDTH  ALU operand A
- Cmd_OpB  out  BUS_WIDTH  ALU operand B
- Cmd_Func  out  4  ALU function, low 4 bits of function byte
- Frame_Error  out  1  one-cycle strobe: unknown opcode or timeout
- Busy  out  1  high while a frame is partially received

## Operation
- Opcodes: 0xAA write (AA, addr, data); 0xBB read (BB, addr); 0xCC ALU (CC, A, B, func); 0xDD ALU no-op (DD, func).
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FN, NOP_FN. Each transition only on Rx_Valid=1 (or timeout).
- IDLE: 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→ALU_A, 0xDD→NOP_FN; any other byte → Frame_Error pulse, stay IDLE.
- WR_ADDR→WR_DATA, ALU_A→ALU_B, ALU_B→ALU_FN, capturing field into a holding register.
- Final byte (WR_DATA, RD_ADDR, ALU_FN, NOP_FN) → IDLE, Cmd_Valid pulse with all fields for that type.
- Bytes after an opcode are payload verbatim; 0xAA etc. inside a frame are not re-decoded.
- Cmd_* fields update only with Cmd_Valid and hold until the next Cmd_Valid. Fields not used by the current type keep previous values.
- Busy = (state != IDLE).
- Timeout: counter of width $clog2(TIMEOUT_CYCLES) clears on every accepted byte and in IDLE; increments each cycle otherwise. Reaching TIMEOUT_CYCLES-1 with no byte that cycle → Frame_Error pulse, state→IDLE, partial frame discarded, no Cmd_Valid.
- Simultaneous timeout expiry and Rx_Valid: byte wins, counter clears, no error.
- Reset mid-frame: state→IDLE, partial frame discarded, no strobe.

## Timing
- Reset values: Cmd_Valid 0, Frame_Error 0, Busy 0, Cmd_Type 00, Cmd_Addr/Data/OpA/OpB/Func all 0; FSM IDLE; counter 0.
- All outputs registered. Final byte at Rx_Valid cycle n → Cmd_Valid=1 at n+1 for exactly one cycle, fields valid same cycle.
- Bad opcode at cycle n → Frame_Error=1 at n+1 for one cycle.
- Busy rises the cycle after the opcode and falls the cycle Cmd_Valid/Frame_Error rises.
- Last byte at n, next opcode at n+1: both accepted; Cmd_Valid at n+1, Busy high again at n+2.
- Timeout: last byte at n → Frame_Error at n+TIMEOUT_CYCLES, Busy low same cycle.
- Cmd_Valid and Frame_Error never high together.

## Test plan
- Reset asserted mid-run → all outputs 0, Busy 0; release and send AA,05,3C → Cmd_Valid one cycle after 3C with Type 00, Addr 5, Data 3C.
- Send BB,0A back-to-back cycles, then CC,12,34,03 → Cmd_Valid Type 01 Addr A, then Type 10 OpA 12 OpB 34 Func 3; Data still 3C.
- Send DD,0F and 0x57 → Cmd_Valid Type 11 Func F; then Frame_Error pulse, no Cmd_Valid, Busy stays 0.
- TIMEOUT_CYCLES=16: send CC,11 then idle → Frame_Error exactly 16 cycles after 11, Busy low; next AA,01,02 decodes normally.
- Send AA,AA,BB → Cmd_Valid Type 00 Addr A (low bits of AA), Data BB; no error.
- TIMEOUT_CYCLES=16: send AA, then 01 on exact expiry cycle → no error, frame continues; 02 → Cmd_Valid Addr 1 Data 02.
